// File: rtl/fft_out_collector_if.sv
// Stream-side bundle of the FFT output collector.
// Data width is 32 when COLLECTOR_SAT16_EN is defined, else 42.
interface fft_out_collector_if #(
`ifdef COLLECTOR_SAT16_EN
    parameter int OW = 32
`else
    parameter int OW = 42
`endif
);
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/fft_out_collector.sv
// Ping-pong collector: banked FFT writes in, natural-order stream out.
// Optional COLLECTOR_SAT16_EN: saturate each component to 16 bits.
module fft_out_collector #(
    parameter int BANKS = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 42
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] outData_0,
    input  logic [DW-1:0] outData_1,
    input  logic [DW-1:0] outData_2,
    input  logic [DW-1:0] outData_3,
    input  logic          outData_0_we,
    input  logic          outData_1_we,
    input  logic          outData_2_we,
    input  logic          outData_3_we,
    input  logic          fft_done,
    output logic          buf_ready,
    fft_out_collector_if.master m_axis,
    output logic          err_overrun,
    output logic          err_short
`ifdef COLLECTOR_SAT16_EN
    ,
    output logic          sat_flag
`endif
);
    localparam int N  = BANKS * DEPTH;
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(N);
`ifdef COLLECTOR_SAT16_EN
    localparam int OW = 32;
`else
    localparam int OW = DW;
`endif

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic [DW-1:0] w_data [BANKS];
    logic          w_we   [BANKS];
    logic [DW-1:0] r_mem  [2][N];
    logic [PW-1:0] r_ptr     [BANKS];
    logic [PW-1:0] w_ptr_nxt [BANKS];
    logic          w_wr      [BANKS];
    logic [IW-1:0] w_waddr   [BANKS];
    logic [1:0]    r_full, r_full_q, w_full_nxt;
    logic          r_wr_sel, r_rd_sel, w_wr_sel_nxt;
    logic          w_commit, w_ov, w_short;
    logic          r_buf_ready, r_err_ov, r_err_short;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [OW-1:0] r_tdata, w_fmt;
    logic [DW-1:0] w_rdata;
    logic          r_tvalid, r_tlast, w_tvalid_nxt, w_tlast_nxt;
    logic          w_load, w_release, w_rd_full, w_hs;

    assign w_data[0] = outData_0;
    assign w_data[1] = outData_1;
    assign w_data[2] = outData_2;
    assign w_data[3] = outData_3;
    assign w_we[0]   = outData_0_we;
    assign w_we[1]   = outData_1_we;
    assign w_we[2]   = outData_2_we;
    assign w_we[3]   = outData_3_we;

    // Same-cycle strobes count toward completeness before commit clears pointers.
    always_comb begin
        w_ov         = 1'b0;
        w_short      = 1'b0;
        w_full_nxt   = r_full;
        w_wr_sel_nxt = r_wr_sel;
        for (int b = 0; b < BANKS; b++) begin
            w_wr[b]      = w_we[b] && !r_full[r_wr_sel] && (r_ptr[b] != PW'(DEPTH));
            w_waddr[b]   = IW'(b * DEPTH) + IW'(r_ptr[b]);
            w_ptr_nxt[b] = w_wr[b] ? r_ptr[b] + PW'(1) : r_ptr[b];
            if (w_we[b] && !w_wr[b]) w_ov = 1'b1;
        end
        w_commit = fft_done && !r_full[r_wr_sel];
        if (fft_done && r_full[r_wr_sel]) w_ov = 1'b1;
        if (w_commit) begin
            for (int b = 0; b < BANKS; b++) begin
                if (w_ptr_nxt[b] != PW'(DEPTH)) w_short = 1'b1;
                w_ptr_nxt[b] = '0;
            end
            w_full_nxt[r_wr_sel] = 1'b1;
            w_wr_sel_nxt         = ~r_wr_sel;
        end
        if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++)
            if (w_wr[b]) r_mem[r_wr_sel][w_waddr[b]] <= w_data[b];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < BANKS; b++) r_ptr[b] <= '0;
            r_full      <= '0;
            r_full_q    <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_buf_ready <= 1'b1;
            r_err_ov    <= 1'b0;
            r_err_short <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS; b++) r_ptr[b] <= w_ptr_nxt[b];
            r_full      <= w_full_nxt;
            r_full_q    <= r_full;
            r_wr_sel    <= w_wr_sel_nxt;
            if (w_release) r_rd_sel <= ~r_rd_sel;
            r_buf_ready <= !w_full_nxt[w_wr_sel_nxt];
            r_err_ov    <= r_err_ov | w_ov;
            r_err_short <= r_err_short | w_short;
        end
    end

    // Read side sees a commit one cycle late, giving valid at commit+2.
    assign w_rd_full = r_full[r_rd_sel] & r_full_q[r_rd_sel];
    assign w_hs      = r_tvalid & m_axis.m_tready;
    assign w_rdata   = r_mem[r_rd_sel][w_idx_nxt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_rd_full) w_state_nxt = S_STREAM;
            S_STREAM: if (w_hs && r_tlast) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load       = 1'b0;
        w_release    = 1'b0;
        w_idx_nxt    = r_idx;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        unique case (r_state)
            S_IDLE: if (w_rd_full) begin
                w_load       = 1'b1;
                w_idx_nxt    = '0;
                w_tvalid_nxt = 1'b1;
                w_tlast_nxt  = 1'b0;
            end
            S_STREAM: if (w_hs) begin
                if (r_tlast) begin
                    w_release    = 1'b1;
                    w_tvalid_nxt = 1'b0;
                    w_tlast_nxt  = 1'b0;
                end else begin
                    w_load      = 1'b1;
                    w_idx_nxt   = r_idx + IW'(1);
                    w_tlast_nxt = (r_idx == IW'(N - 2));
                end
            end
            default: ;
        endcase
    end

`ifdef COLLECTOR_SAT16_EN
    localparam int HW = DW / 2;

    function automatic logic [16:0] sat16(input logic [HW-1:0] v);
        logic [HW-16:0] hi;
        hi = v[HW-1:15];
        if (!v[HW-1] && (|hi))   return {1'b1, 16'h7FFF};
        if (v[HW-1] && !(&hi))   return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    logic [16:0] w_sre, w_sim;
    logic        r_sat;

    assign w_sre = sat16(w_rdata[HW-1:0]);
    assign w_sim = sat16(w_rdata[DW-1:HW]);
    assign w_fmt = {w_sim[15:0], w_sre[15:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_sat <= 1'b0;
        else if (w_load) r_sat <= r_sat | w_sre[16] | w_sim[16];
    end
    assign sat_flag = r_sat;
`else
    assign w_fmt = w_rdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            if (w_load) r_tdata <= w_fmt;
        end
    end

    assign m_axis.m_tdata  = r_tdata;
    assign m_axis.m_tvalid = r_tvalid;
    assign m_axis.m_tlast  = r_tlast;
    assign buf_ready       = r_buf_ready;
    assign err_overrun     = r_err_ov;
    assign err_short       = r_err_short;
endmodule

// File: tb/tb_fft_out_collector.sv
// Bench for fft_out_collector: random frames, frame-level model, scoreboard.
module tb_fft_out_collector;
    localparam int DW = 42;
    localparam int DEPTH = 4;
    localparam int N = 16;
`ifdef COLLECTOR_SAT16_EN
    localparam int OW = 32;
`else
    localparam int OW = 42;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic we0 = 1'b0, we1 = 1'b0, we2 = 1'b0, we3 = 1'b0;
    logic fft_done = 1'b0;
    logic buf_ready, err_overrun, err_short;
`ifdef COLLECTOR_SAT16_EN
    logic sat_flag;
`endif

    fft_out_collector_if bus ();

    fft_out_collector dut (
        .clk(clk), .rst(rst),
        .outData_0(d0), .outData_1(d1), .outData_2(d2), .outData_3(d3),
        .outData_0_we(we0), .outData_1_we(we1),
        .outData_2_we(we2), .outData_3_we(we3),
        .fft_done(fft_done), .buf_ready(buf_ready), .m_axis(bus),
        .err_overrun(err_overrun), .err_short(err_short)
`ifdef COLLECTOR_SAT16_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_pop = 0;
    logic [OW-1:0] exp_d [$];
    logic          exp_l [$];

    // Frame-level model: two buffers, write select, frames held.
    logic [DW-1:0] m_buf [2][N];
    int  m_wsel = 0, m_inflight = 0;
    int  m_ptr [4] = '{0, 0, 0, 0};
    bit  m_ov = 0, m_short = 0;

    int  tr_mode = 0;
    bit  tr_val = 0;
    int  last_gap = -1;

    task automatic chk1(input string nm, input logic a, input logic e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chkn(input string nm, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic logic [15:0] ref_sat(input logic [20:0] v);
        int s;
        logic [31:0] t;
        s = int'($signed(v));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        t = s;
        return t[15:0];
    endfunction

    function automatic logic [OW-1:0] exp_fmt(input logic [DW-1:0] raw);
`ifdef COLLECTOR_SAT16_EN
        return {ref_sat(raw[41:21]), ref_sat(raw[20:0])};
`else
        return raw;
`endif
    endfunction

    task automatic model_write(input int b, input logic [DW-1:0] d);
        if (m_inflight < 2 && m_ptr[b] < DEPTH) begin
            m_buf[m_wsel][b*DEPTH + m_ptr[b]] = d;
            m_ptr[b]++;
        end else begin
            m_ov = 1;
        end
    endtask

    task automatic model_commit();
        if (m_inflight < 2) begin
            for (int i = 0; i < N; i++) begin
                exp_d.push_back(exp_fmt(m_buf[m_wsel][i]));
                exp_l.push_back(i == N-1);
            end
            for (int b = 0; b < 4; b++) if (m_ptr[b] < DEPTH) m_short = 1;
            m_ptr = '{0, 0, 0, 0};
            m_wsel ^= 1;
            m_inflight++;
        end else begin
            m_ov = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random data, 1: data = stream index, 2: index with clip word at 0
    task automatic write_frame(input int n [4], input int mode, input bit dense);
        int cnt [4];
        logic [DW-1:0] d;
        logic [DW-1:0] dv [4];
        logic [3:0] we;
        logic [20:0] im;
        cnt = '{0, 0, 0, 0};
        while (cnt[0] < n[0] || cnt[1] < n[1] || cnt[2] < n[2] || cnt[3] < n[3]) begin
            we = '0;
            for (int b = 0; b < 4; b++) begin
                dv[b] = '0;
                if (cnt[b] < n[b] && (dense || $urandom_range(0, 1) == 1)) begin
                    if (mode == 0) d = {$urandom, $urandom};
                    else d = DW'(b*DEPTH + cnt[b]);
                    if (mode == 2 && b == 0 && cnt[b] == 0) begin
                        im = 21'(-300000);
                        d = {im, 21'h0FFFFF};
                    end
                    dv[b] = d;
                    we[b] = 1'b1;
                    model_write(b, d);
                    cnt[b]++;
                end
            end
            d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
            we0 = we[0]; we1 = we[1]; we2 = we[2]; we3 = we[3];
            tick();
        end
        we0 = 0; we1 = 0; we2 = 0; we3 = 0;
        fft_done = 1'b1;
        model_commit();
        tick();
        fft_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_d.size() > 0; i++) tick();
        chkn("drain_remaining", exp_d.size(), 0);
        repeat (3) tick();
    endtask

    always @(posedge clk) begin
        #1;
        if (tr_mode == 1) bus.m_tready = ($urandom_range(0, 3) != 1) ? 1'b1 : 1'b0;
        else bus.m_tready = tr_val;
    end

    // Monitor: scoreboard pop, stall stability, inter-frame gap.
    bit prev_stall = 0, counting = 0;
    int gap = 0;
    logic [OW-1:0] prev_d, ed;
    logic prev_l, el;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
            counting = 0;
        end else begin
            if (prev_stall) begin
                chk1("stall_valid", bus.m_tvalid, 1'b1);
                chk1("stall_last", bus.m_tlast, prev_l);
                n_tests++;
                if (bus.m_tdata !== prev_d) begin
                    n_fail++;
                    $display("FAIL stall_data: got %0h expected %0h", bus.m_tdata, prev_d);
                end
            end
            if (counting) begin
                if (bus.m_tvalid) begin
                    last_gap = gap;
                    counting = 0;
                end else gap++;
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_d.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.m_tdata);
                end else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    n_tests++;
                    if (bus.m_tdata !== ed) begin
                        n_fail++;
                        $display("FAIL word%0d_data: got %0h expected %0h",
                                 n_pop, bus.m_tdata, ed);
                    end
                    chk1("word_last", bus.m_tlast, el);
                    n_pop++;
                    if (el) begin
                        m_inflight--;
                        counting = 1;
                        gap = 0;
                    end
                end
            end
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_d = bus.m_tdata;
            prev_l = bus.m_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int hi, base;
    initial begin
        bus.m_tready = 1'b0;
        repeat (3) tick();
        chk1("rst_valid", bus.m_tvalid, 1'b0);
        chk1("rst_last", bus.m_tlast, 1'b0);
        chk1("rst_data_zero", bus.m_tdata == '0, 1'b1);
        chk1("rst_buf_ready", buf_ready, 1'b1);
        chk1("rst_err_ov", err_overrun, 1'b0);
        chk1("rst_err_short", err_short, 1'b0);
        rst = 1'b1;
        tr_val = 1;
        repeat (2) tick();

        // single frame, sequential data, latency and burst length
        write_frame('{4, 4, 4, 4}, 1, 0);
        chk1("lat_e0", bus.m_tvalid, 1'b0);
        chk1("single_buf_ready", buf_ready, 1'b1);
        tick();
        chk1("lat_e1", bus.m_tvalid, 1'b0);
        tick();
        chk1("lat_e2", bus.m_tvalid, 1'b1);
        hi = 0;
        while (bus.m_tvalid && hi < 40) begin
            hi++;
            tick();
        end
        chkn("burst_len", hi, 16);
        wait_drain(50);
        chk1("single_err_ov", err_overrun, 1'b0);
        chk1("single_err_short", err_short, 1'b0);

        // backpressure
        tr_mode = 1;
        write_frame('{4, 4, 4, 4}, 0, 0);
        wait_drain(200);
        tr_mode = 0;

        // ping-pong
        last_gap = -1;
        write_frame('{4, 4, 4, 4}, 0, 1);
        write_frame('{4, 4, 4, 4}, 0, 1);
        tick();
        chk1("pp_both_full", buf_ready, 1'b0);
        wait_drain(100);
        chkn("pp_gap", last_gap, 1);
        chk1("pp_buf_ready", buf_ready, 1'b1);

        // overrun
        tr_val = 0;
        repeat (2) tick();
        write_frame('{4, 4, 4, 4}, 0, 1);
        write_frame('{4, 4, 4, 4}, 0, 1);
        write_frame('{4, 4, 4, 4}, 0, 1);
        tick();
        chk1("ov_err", err_overrun, m_ov);
        chk1("ov_buf_ready", buf_ready, 1'b0);
        tr_val = 1;
        wait_drain(150);

        // short frame, stale entries from the same buffer
        write_frame('{4, 4, 4, 2}, 0, 0);
        chk1("short_err", err_short, m_short);
        wait_drain(100);

        // reset mid-stream
        base = n_pop;
        write_frame('{4, 4, 4, 4}, 0, 1);
        for (int i = 0; i < 100 && (n_pop - base) < 7; i++) tick();
        chkn("rst_mid_words", n_pop - base, 7);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk1("rst_mid_valid", bus.m_tvalid, 1'b0);
        chk1("rst_mid_buf_ready", buf_ready, 1'b1);
        chk1("rst_mid_err_ov", err_overrun, 1'b0);
        chk1("rst_mid_err_short", err_short, 1'b0);
        exp_d.delete();
        exp_l.delete();
        m_inflight = 0;
        m_wsel = 0;
        m_ptr = '{0, 0, 0, 0};
        m_ov = 0;
        m_short = 0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk1("post_rst_idle", bus.m_tvalid, 1'b0);
        write_frame('{4, 4, 4, 4}, 1, 0);
        wait_drain(100);
`ifdef COLLECTOR_SAT16_EN
        chk1("sat_clear", sat_flag, 1'b0);
        write_frame('{4, 4, 4, 4}, 2, 1);
        wait_drain(100);
        chk1("sat_set", sat_flag, 1'b1);
`endif
        chkn("final_queue", exp_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
